// File: rtl/vga_mem_prefetch_buff.sv
// N-entry circular prefetch buffer between frame BRAM port A and the VGA pixel path.
// Optional VGA_MEM_BUFF_RESYNC_EN: on a tag mismatch, flush and refetch from the displayed row + 1.
module vga_mem_prefetch_buff #(
    parameter int PXL_WIDTH      = 1,
    parameter int PXL_PER_ROW    = 8,
    parameter int MEM_DEPTH      = 38400,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int BUFF_COUNT     = 2,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic                                disp_en_i,
    input  logic [MEM_ADDR_WIDTH-1:0]           disp_addr_ctr_i,
    input  logic [$clog2(PXL_PER_ROW)-1:0]      disp_pxl_ctr_i,
    input  logic [PXL_PER_ROW*PXL_WIDTH-1:0]    mem_data_i,
    output logic                                mem_en_o,
    output logic [MEM_ADDR_WIDTH-1:0]           mem_addr_o,
    output logic [PXL_WIDTH-1:0]                disp_pxl_o,
    output logic                                disp_blank_o,
    output logic                                ready_o,
    output logic                                underrun_o
);

    localparam int PIDX_W = $clog2(PXL_PER_ROW);
    localparam int PTR_W  = (BUFF_COUNT > 1) ? $clog2(BUFF_COUNT) : 1;
    localparam int CNT_W  = $clog2(BUFF_COUNT + 1);

    localparam logic [PTR_W-1:0]          PTR_LAST  = PTR_W'(BUFF_COUNT - 1);
    localparam logic [CNT_W-1:0]          CNT_FULL  = CNT_W'(BUFF_COUNT);
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_LAST = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [PIDX_W-1:0]         PXL_LAST  = PIDX_W'(PXL_PER_ROW - 1);

`ifdef VGA_MEM_BUFF_RESYNC_EN
    typedef enum logic [1:0] {IDLE, FILL, RUN, RESYNC} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
`endif

    // Each entry holds one BRAM row split into pixels, plus the row address it came from.
    logic [PXL_PER_ROW-1:0][PXL_WIDTH-1:0] buf_data [BUFF_COUNT];
    logic [MEM_ADDR_WIDTH-1:0]             buf_tag  [BUFF_COUNT];

    state_t                    state, state_nxt;
    logic [PTR_W-1:0]          head, tail;
    logic [CNT_W-1:0]          count;
    logic [MEM_ADDR_WIDTH-1:0] fetch_addr;
    logic [MEM_RD_LATENCY-1:0] rd_pipe;

    logic in_flight;
    logic capture;
    logic store;
    logic head_hit;
    logic fetch_active;
    logic issue;
    logic serve;
    logic pop;
    logic miss;
    logic flush;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [MEM_ADDR_WIDTH-1:0] addr_inc(input logic [MEM_ADDR_WIDTH-1:0] a);
        return (a == ADDR_LAST) ? '0 : a + 1'b1;
    endfunction

    // The issue cycle itself counts as in flight so that only one read is ever outstanding.
    assign in_flight = mem_en_o | (|rd_pipe);
    assign capture   = rd_pipe[MEM_RD_LATENCY-1];
    assign store     = capture && !flush;
    assign head_hit  = (count != '0) && (buf_tag[head] == disp_addr_ctr_i);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        fetch_active = 1'b0;
        serve        = 1'b0;
        pop          = 1'b0;
        miss         = 1'b0;
        flush        = 1'b0;
        case (state)
            IDLE: state_nxt = FILL;
            FILL: begin
                fetch_active = 1'b1;
                if (count == CNT_FULL) state_nxt = RUN;
            end
            RUN: begin
                fetch_active = 1'b1;
                if (disp_en_i) begin
                    if (head_hit) begin
                        serve = 1'b1;
                        pop   = (disp_pxl_ctr_i == PXL_LAST);
                    end else begin
                        miss = 1'b1;
`ifdef VGA_MEM_BUFF_RESYNC_EN
                        flush        = 1'b1;
                        fetch_active = 1'b0;
                        state_nxt    = RESYNC;
`endif
                    end
                end
            end
`ifdef VGA_MEM_BUFF_RESYNC_EN
            RESYNC: state_nxt = FILL;
`endif
            default: state_nxt = IDLE;
        endcase
        issue = fetch_active && !in_flight && (count < CNT_FULL);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mem_en_o     <= 1'b0;
            mem_addr_o   <= '0;
            fetch_addr   <= '0;
            rd_pipe      <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            disp_pxl_o   <= '0;
            disp_blank_o <= 1'b1;
            ready_o      <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            mem_en_o <= issue;
            if (issue) begin
                mem_addr_o <= fetch_addr;
                fetch_addr <= addr_inc(fetch_addr);
            end
            rd_pipe <= MEM_RD_LATENCY'({rd_pipe, mem_en_o});

            if (store) tail <= ptr_inc(tail);
            if (pop)   head <= ptr_inc(head);
            case ({store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Resync drops everything, including a read already on its way back.
            if (flush) begin
                rd_pipe    <= '0;
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                fetch_addr <= addr_inc(disp_addr_ctr_i);
            end

            ready_o <= ready_o | (state_nxt == RUN);
            if (miss) underrun_o <= 1'b1;

            disp_blank_o <= !serve;
            disp_pxl_o   <= serve ? buf_data[head][disp_pxl_ctr_i] : '0;
        end
    end

    // NOTE: entry storage has no reset; count and head decide what is valid, so stale contents are never read.
    // mem_addr_o still holds the issued address when its data returns, so it doubles as the tag.
    always_ff @(posedge clk_i) begin
        if (store) begin
            buf_data[tail] <= mem_data_i;
            buf_tag[tail]  <= mem_addr_o;
        end
    end

endmodule

// File: tb/tb_vga_mem_prefetch_buff.sv
// Scoreboard bench: instance A uses defaults, instance B uses wide pixels, 4 entries,
// 2-cycle BRAM latency and a 6-row memory so the address wrap is reachable.
`timescale 1ns/1ps
module tb_vga_mem_prefetch_buff;

    localparam int B_AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- instance A (defaults) ----------------
    logic        a_rstn;
    logic        a_en = 1'b0;
    logic [15:0] a_addr = '0;
    logic [2:0]  a_pxl = '0;
    logic [7:0]  a_mem_data;
    logic        a_mem_en;
    logic [15:0] a_mem_addr;
    logic [0:0]  a_pix;
    logic        a_blank, a_ready, a_underrun;

    vga_mem_prefetch_buff u_dut_a (
        .clk_i(clk), .rstn_i(a_rstn), .disp_en_i(a_en), .disp_addr_ctr_i(a_addr),
        .disp_pxl_ctr_i(a_pxl), .mem_data_i(a_mem_data), .mem_en_o(a_mem_en),
        .mem_addr_o(a_mem_addr), .disp_pxl_o(a_pix), .disp_blank_o(a_blank),
        .ready_o(a_ready), .underrun_o(a_underrun)
    );

    // BRAM A: row n = n[7:0] ^ 8'hA5, valid only in the single cycle after the read; inverted otherwise.
    logic       a_rd_v = 1'b0;
    logic [7:0] a_rd_row = '0;
    always @(posedge clk) begin
        a_rd_v   <= a_mem_en;
        a_rd_row <= a_mem_addr[7:0] ^ 8'hA5;
    end
    assign a_mem_data = a_rd_v ? a_rd_row : ~a_rd_row;

    // ---------------- instance B (wide, deep, slow, small memory) ----------------
    logic            b_rstn;
    logic            b_en = 1'b0;
    logic [B_AW-1:0] b_addr = '0;
    logic [2:0]      b_pxl = '0;
    logic [23:0]     b_mem_data;
    logic            b_mem_en;
    logic [B_AW-1:0] b_mem_addr;
    logic [2:0]      b_pix;
    logic            b_blank, b_ready, b_underrun;

    vga_mem_prefetch_buff #(
        .PXL_WIDTH(3), .PXL_PER_ROW(8), .MEM_DEPTH(6), .MEM_ADDR_WIDTH(B_AW),
        .BUFF_COUNT(4), .MEM_RD_LATENCY(2)
    ) u_dut_b (
        .clk_i(clk), .rstn_i(b_rstn), .disp_en_i(b_en), .disp_addr_ctr_i(b_addr),
        .disp_pxl_ctr_i(b_pxl), .mem_data_i(b_mem_data), .mem_en_o(b_mem_en),
        .mem_addr_o(b_mem_addr), .disp_pxl_o(b_pix), .disp_blank_o(b_blank),
        .ready_o(b_ready), .underrun_o(b_underrun)
    );

    // BRAM B: pixel k of row n is (n+k) mod 8; valid only exactly two cycles after the read.
    function automatic logic [23:0] row_b(input logic [B_AW-1:0] n);
        logic [23:0] r;
        for (int k = 0; k < 8; k++) r[k*3 +: 3] = 3'(32'(n) + k);
        return r;
    endfunction

    logic [1:0]      b_v = '0;
    logic [B_AW-1:0] b_a1 = '0, b_a2 = '0;
    always @(posedge clk) begin
        b_v  <= {b_v[0], b_mem_en};
        b_a1 <= b_mem_addr;
        b_a2 <= b_a1;
    end
    assign b_mem_data = b_v[1] ? row_b(b_a2) : ~row_b(b_a2);

    // ---------------- scoreboards and monitors ----------------
    int         a_rd_q[$];
    int         b_rd_q[$];
    logic [1:0] a_px_q[$];
    logic [3:0] b_px_q[$];

    logic a_act = 1'b0, a_act_d = 1'b0;
    logic b_act = 1'b0, b_act_d = 1'b0;
    always @(posedge clk) begin
        a_act_d <= a_act;
        b_act_d <= b_act;
    end

    always @(negedge clk) begin
        if (a_act_d) begin
            if (a_px_q.size() == 0) begin
                total++; bad++;
                $display("FAIL a_pix_extra: got blank=%0d pxl=%0d with nothing expected", a_blank, a_pix);
            end else check("a_pix", 32'({a_blank, a_pix}), 32'(a_px_q.pop_front()));
        end
        if (a_mem_en) begin
            if (a_rd_q.size() == 0) begin
                total++; bad++;
                $display("FAIL a_rd_unexpected: got read addr %0d expected none", a_mem_addr);
            end else check("a_rd_addr", 32'(a_mem_addr), 32'(a_rd_q.pop_front()));
        end
        if (b_act_d) begin
            if (b_px_q.size() == 0) begin
                total++; bad++;
                $display("FAIL b_pix_extra: got blank=%0d pxl=%0d with nothing expected", b_blank, b_pix);
            end else check("b_pix", 32'({b_blank, b_pix}), 32'(b_px_q.pop_front()));
        end
        if (b_mem_en) begin
            if (b_rd_q.size() == 0) begin
                total++; bad++;
                $display("FAIL b_rd_unexpected: got read addr %0d expected none", b_mem_addr);
            end else check("b_rd_addr", 32'(b_mem_addr), 32'(b_rd_q.pop_front()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic a_drive(input logic en, input logic [15:0] addr, input int p, input logic [1:0] exp);
        @(negedge clk);
        a_en = en; a_addr = addr; a_pxl = 3'(p); a_act = 1'b1;
        a_px_q.push_back(exp);
    endtask

    task automatic a_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            a_en = 1'b0; a_act = 1'b0;
        end
    endtask

    task automatic a_row(input logic [15:0] addr, input logic [7:0] row);
        for (int p = 0; p < 8; p++) a_drive(1'b1, addr, p, {1'b0, row[p]});
    endtask

    task automatic a_wait_ready(input string name);
        int n = 0;
        while (a_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(a_ready), 32'd1);
    endtask

    task automatic a_check_reset(input string tag);
        check({tag, "_mem_en"},   32'(a_mem_en),   32'd0);
        check({tag, "_mem_addr"}, 32'(a_mem_addr), 32'd0);
        check({tag, "_pxl"},      32'(a_pix),      32'd0);
        check({tag, "_blank"},    32'(a_blank),    32'd1);
        check({tag, "_ready"},    32'(a_ready),    32'd0);
        check({tag, "_underrun"}, 32'(a_underrun), 32'd0);
    endtask

    task automatic b_drive(input logic [B_AW-1:0] addr, input int p, input logic [3:0] exp);
        @(negedge clk);
        b_en = 1'b1; b_addr = addr; b_pxl = 3'(p); b_act = 1'b1;
        b_px_q.push_back(exp);
    endtask

    task automatic b_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            b_en = 1'b0; b_act = 1'b0;
        end
    endtask

    task automatic b_row(input logic [B_AW-1:0] tag);
        for (int p = 0; p < 8; p++) b_drive(tag, p, {1'b0, 3'(32'(tag) + p)});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        a_rstn = 1'b1;
        b_rstn = 1'b1;
        #1;
        a_rstn = 1'b0;
        b_rstn = 1'b0;
        repeat (3) @(negedge clk);
        a_check_reset("a_rst");

        // Prime: two reads (0, 1); blank during fill even with disp_en high.
        a_rd_q.push_back(0);
        a_rd_q.push_back(1);
        a_rstn = 1'b1;
        for (int i = 0; i < 4; i++) a_drive(1'b1, 16'd0, 0, 2'b10);
        a_idle(1);
        a_wait_ready("a_ready_prime");
        a_idle(5);
        check("a_rd_q_prime", 32'(a_rd_q.size()), 32'd0);
        check("a_underrun_fill", 32'(a_underrun), 32'd0);

        // Stream: row 0 = 1010_0101, pops after pixel 7 and triggers read 2.
        a_rd_q.push_back(2);
        a_row(16'd0, 8'hA5);
        a_rd_q.push_back(3);
        a_row(16'd1, 8'hA4);
        check("a_underrun_stream", 32'(a_underrun), 32'd0);

        // Mismatch: head tag 3 while display asks for row 5.
`ifdef VGA_MEM_BUFF_RESYNC_EN
        a_row(16'd2, 8'hA7);
        a_drive(1'b1, 16'd5, 0, 2'b10);
        a_rd_q.push_back(6);
        a_rd_q.push_back(7);
`else
        a_rd_q.push_back(4);
        a_row(16'd2, 8'hA7);
        a_drive(1'b1, 16'd5, 0, 2'b10);
`endif
        a_idle(15);
        check("a_underrun_miss", 32'(a_underrun), 32'd1);
        check("a_ready_hold", 32'(a_ready), 32'd1);
`ifdef VGA_MEM_BUFF_RESYNC_EN
        a_rd_q.push_back(8);
        a_row(16'd6, 8'hA3);
`else
        a_rd_q.push_back(5);
        a_row(16'd3, 8'hA6);
`endif
        a_idle(8);
        check("a_underrun_sticky", 32'(a_underrun), 32'd1);
        check("a_rd_q_stream", 32'(a_rd_q.size()), 32'd0);

        // Reset mid-read: pulse reset in the cycle after mem_en; the returning data must be dropped.
        @(negedge clk);
        a_rstn = 1'b0;
        @(negedge clk);
        a_check_reset("a_rst2");
        a_rd_q.push_back(0);
        a_rstn = 1'b1;
        n = 0;
        while (a_mem_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("a_rd_seen", 32'(a_mem_en), 32'd1);
        @(negedge clk);
        a_rstn = 1'b0;
        #1;
        a_check_reset("a_rst_mid");
        #1;
        a_rstn = 1'b1;
        a_rd_q.push_back(0);
        a_rd_q.push_back(1);
        a_wait_ready("a_ready_refill");
        check("a_rd_q_refill", 32'(a_rd_q.size()), 32'd0);
        a_rd_q.push_back(2);
        a_row(16'd0, 8'hA5);
        a_idle(6);
        check("a_rd_q_final", 32'(a_rd_q.size()), 32'd0);

        // Instance B: four fetches before ready, then stream rows 0..5 and wrap to 0.
        for (int i = 0; i < 4; i++) b_rd_q.push_back(i);
        @(negedge clk);
        b_rstn = 1'b1;
        n = 0;
        while (b_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b_ready_prime", 32'(b_ready), 32'd1);
        check("b_fetch_before_ready", 32'(b_rd_q.size()), 32'd0);
        b_idle(4);
        for (int r = 0; r < 7; r++) begin
            b_rd_q.push_back((4 + r) % 6);
            b_row(B_AW'(r % 6));
        end
        b_idle(10);
        check("b_rd_q_final", 32'(b_rd_q.size()), 32'd0);
        check("b_underrun", 32'(b_underrun), 32'd0);

        check("a_px_q_final", 32'(a_px_q.size()), 32'd0);
        check("b_px_q_final", 32'(b_px_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
